axi_read_arbiter: RTL

- Round-robin arbiter that shares one AXI4 read-only slave port (AR + R channels, e.g. the RAM slave) between NUM_MASTERS requesters.
- Grants the AR channel to one master, then routes all R beats of that burst back to it; one outstanding burst at a time, no IDs.
- Sits between the requesters and the slave.

---
 rtl/axi_read_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/axi_read_arbiter.sv
// ---------------------------------------------------------------------------
// axi_read_arbiter
//
// Purpose:
//   Round-robin arbiter that shares one AXI4 read-only slave port (AR and R
//   channels) between NUM_MASTERS requesters. A master is granted the AR
//   channel, and then every R beat of that burst is routed back to it. Only
//   one burst is outstanding at a time, and no IDs are used.
//
// Optional feature:
//   AXI_READ_ARBITER_BEAT_CHECK_EN - when defined, the arbiter counts R beats
//   against arlen+1. It raises the sticky protocol_err flag when s_rlast and
//   the beat count disagree. When undefined, protocol_err is tied to 0.
//
// Ports:
//   aclk, areset         clock (rising edge), asynchronous active-high reset
//   m_ar*                per-master AR channel, master i in slice i
//   m_r*                 per-master R channel; data/resp/last are broadcast,
//                        and only m_rvalid selects the owner
//   s_ar*, s_r*          single AXI4 read slave port
//   protocol_err         sticky burst-length mismatch flag
// ---------------------------------------------------------------------------
module axi_read_arbiter #(
   parameter int NUM_MASTERS   = 2,
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                              aclk,
   input  logic                              areset,
   input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] m_araddr,
   input  logic [NUM_MASTERS*8-1:0]          m_arlen,
   input  logic [NUM_MASTERS*3-1:0]          m_arsize,
   input  logic [NUM_MASTERS*2-1:0]          m_arburst,
   input  logic [NUM_MASTERS-1:0]            m_arvalid,
   output logic [NUM_MASTERS-1:0]            m_arready,
   output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
   output logic [NUM_MASTERS*2-1:0]          m_rresp,
   output logic [NUM_MASTERS-1:0]            m_rlast,
   output logic [NUM_MASTERS-1:0]            m_rvalid,
   input  logic [NUM_MASTERS-1:0]            m_rready,
   output logic [ADDRESS_WIDTH-1:0]          s_araddr,
   output logic [7:0]                        s_arlen,
   output logic [2:0]                        s_arsize,
   output logic [1:0]                        s_arburst,
   output logic                              s_arvalid,
   input  logic                              s_arready,
   input  logic [DATA_WIDTH-1:0]             s_rdata,
   input  logic [1:0]                        s_rresp,
   input  logic                              s_rlast,
   input  logic                              s_rvalid,
   output logic                              s_rready,
   output logic                              protocol_err
);

   localparam int GRANT_WIDTH = $clog2(NUM_MASTERS);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t                 state_q, state_d;
   logic [GRANT_WIDTH-1:0] grant_q, grant_d;
   logic [GRANT_WIDTH-1:0] last_grant_q, last_grant_d;
   logic                   found;
   logic                   ar_hs;
   logic                   r_hs;

   // The granted master's AR fields drive the slave directly. Outside ADDR
   // they are don't-care because s_arvalid is low.
   assign s_araddr  = m_araddr[int'(grant_q)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
   assign s_arlen   = m_arlen[int'(grant_q)*8 +: 8];
   assign s_arsize  = m_arsize[int'(grant_q)*3 +: 3];
   assign s_arburst = m_arburst[int'(grant_q)*2 +: 2];
   assign s_arvalid = (state_q == ADDR) && m_arvalid[grant_q];

   // Read data is broadcast, so no wide mux is needed. Only m_rvalid tells a
   // master that the beat is its own.
   assign m_rdata = {NUM_MASTERS{s_rdata}};
   assign m_rresp = {NUM_MASTERS{s_rresp}};
   assign m_rlast = {NUM_MASTERS{s_rlast}};

   assign ar_hs = s_arvalid && s_arready;
   assign r_hs  = (state_q == DATA) && s_rvalid && s_rready;

   // Handshake steering. Readies and valids go only to the granted master,
   // and all of them are held low in IDLE. This keeps a combinational path
   // from m_arvalid to m_arready from forming while arbitration is pending.
   always_comb begin
      m_arready = '0;
      m_rvalid  = '0;
      s_rready  = 1'b0;
      if (state_q == ADDR) begin
         m_arready[grant_q] = s_arready;
      end
      if (state_q == DATA) begin
         m_rvalid[grant_q] = s_rvalid;
         s_rready          = m_rready[grant_q];
      end
   end

   // Next-state logic. In IDLE the search starts just after the last served
   // master and wraps, which produces strict rotation among persistent
   // requesters. The burst ends on s_rlast and does not depend on a beat
   // count.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      found        = 1'b0;
      case (state_q)
         IDLE: begin
            for (int k = 1; k <= NUM_MASTERS; k++) begin
               if (!found && m_arvalid[(int'(last_grant_q) + k) % NUM_MASTERS]) begin
                  found   = 1'b1;
                  grant_d = GRANT_WIDTH'((int'(last_grant_q) + k) % NUM_MASTERS);
               end
            end
            if (found) begin
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (ar_hs) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (r_hs && s_rlast) begin
               state_d      = IDLE;
               last_grant_d = grant_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers. last_grant resets to the highest index, so that
   // master 0 has first priority after reset.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= GRANT_WIDTH'(NUM_MASTERS - 1);
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

`ifdef AXI_READ_ARBITER_BEAT_CHECK_EN
   logic [8:0] beats_left_q, beats_left_d;
   logic       protocol_err_q, protocol_err_d;

   // beats_left is 9 bits wide, so arlen=255 loads 256 without wrapping.
   // An error is flagged when rlast and "this is the final counted beat"
   // disagree in either direction.
   always_comb begin
      beats_left_d   = beats_left_q;
      protocol_err_d = protocol_err_q;
      if (ar_hs) begin
         beats_left_d = {1'b0, s_arlen} + 9'd1;
      end else if (r_hs) begin
         beats_left_d = beats_left_q - 9'd1;
         if (s_rlast != (beats_left_q == 9'd1)) begin
            protocol_err_d = 1'b1;
         end
      end
   end

   // Beat counter and sticky error flag. Only areset clears them.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         beats_left_q   <= '0;
         protocol_err_q <= 1'b0;
      end else begin
         beats_left_q   <= beats_left_d;
         protocol_err_q <= protocol_err_d;
      end
   end

   assign protocol_err = protocol_err_q;
`else
   assign protocol_err = 1'b0;
`endif

endmodule
